// File: rtl/dma_start_sched_if.sv
// Descriptor-start scheduler bus: start/abort requests in, load request and
// status out.
//   master : register/chaining side (drives starts, aborts, ack, done)
//   slave  : scheduler side (drives ldDscrptr, ldDscrptrNum, pendStat,
//            outstandingCnt)
// hiPrio exists only when DMA_START_HI_PRIO_EN is defined.
interface dma_start_sched_if #(
  parameter int unsigned NUM_INT_BDS       = 4,
  parameter int unsigned NUM_INT_BDS_WIDTH = 2
);
  logic [NUM_INT_BDS-1:0]       strtDMAOp;
  logic [NUM_INT_BDS-1:0]       strtDMAOpInt;
  logic [NUM_INT_BDS-1:0]       abortDMAOp;
`ifdef DMA_START_HI_PRIO_EN
  logic [NUM_INT_BDS-1:0]       hiPrio;
`endif
  logic                         ldIntDscrptrAck;
  logic                         dscrptrDone;
  logic                         ldDscrptr;
  logic [NUM_INT_BDS_WIDTH-1:0] ldDscrptrNum;
  logic [NUM_INT_BDS-1:0]       pendStat;
  logic [3:0]                   outstandingCnt;

  modport master (
`ifdef DMA_START_HI_PRIO_EN
    output hiPrio,
`endif
    output strtDMAOp, strtDMAOpInt, abortDMAOp, ldIntDscrptrAck, dscrptrDone,
    input  ldDscrptr, ldDscrptrNum, pendStat, outstandingCnt
  );

  modport slave (
`ifdef DMA_START_HI_PRIO_EN
    input  hiPrio,
`endif
    input  strtDMAOp, strtDMAOpInt, abortDMAOp, ldIntDscrptrAck, dscrptrDone,
    output ldDscrptr, ldDscrptrNum, pendStat, outstandingCnt
  );
endinterface

// File: rtl/dma_start_sched.sv
// DMA descriptor start scheduler. Collects per-descriptor start pulses into
// pending bits, picks one round-robin, and issues a held load request to the
// descriptor fetch engine while limiting loaded-but-unfinished descriptors.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : dma_start_sched_if.slave (starts/aborts/ack/done in,
//            ldDscrptr/ldDscrptrNum/pendStat/outstandingCnt out)
// Optional feature macro DMA_START_HI_PRIO_EN: adds hiPrio class that always
// wins over normal descriptors, each class with its own round-robin pointer.
module dma_start_sched #(
  parameter int unsigned NUM_INT_BDS       = 4,
  parameter int unsigned NUM_INT_BDS_WIDTH = 2,
  parameter int unsigned MAX_OUTSTANDING   = 2
) (
  input logic             clock,
  input logic             resetn,
  dma_start_sched_if.slave bus
);
  localparam int unsigned N = NUM_INT_BDS;
  localparam int unsigned W = NUM_INT_BDS_WIDTH;

  typedef logic [W-1:0] idx_t;
  typedef logic [N-1:0] vec_t;
  typedef enum logic {IDLE, REQ} state_t;

  state_t     state;
  vec_t       pend;
  vec_t       pendNext;
  vec_t       ackClr;
  idx_t       rrPtr;
  logic       ldReq;
  idx_t       ldNum;
  logic [3:0] cnt;
  logic       doAck;
  logic       winValid;
  idx_t       winIdx;
  idx_t       nextPtr;
`ifdef DMA_START_HI_PRIO_EN
  idx_t       hiPtr;
  logic       grantHi;
  logic       winHi;
  logic       hiFound;
  logic       loFound;
  idx_t       hiIdx;
  idx_t       loIdx;
`endif

  // First set bit of req searching upward from ptr, wrapping at N.
  function automatic void rrPick(input vec_t req, input idx_t ptr,
                                 output logic found, output idx_t idx);
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = (32'(ptr) + i) % N;
      if (!found && req[W'(j)]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  endfunction

  // Arbitration over current pending bits
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
`ifdef DMA_START_HI_PRIO_EN
    winHi   = 1'b0;
    hiFound = 1'b0;
    loFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    rrPick(pend & bus.hiPrio, hiPtr, hiFound, hiIdx);
    rrPick(pend & ~bus.hiPrio, rrPtr, loFound, loIdx);
    if (hiFound) begin
      winValid = 1'b1;
      winIdx   = hiIdx;
      winHi    = 1'b1;
    end else if (loFound) begin
      winValid = 1'b1;
      winIdx   = loIdx;
    end
`else
    rrPick(pend, rrPtr, winValid, winIdx);
`endif
  end

  // Pending update: ack clears granted bit, new start re-sets it, abort wins
  always_comb begin
    doAck    = (state == REQ) && bus.ldIntDscrptrAck;
    ackClr   = doAck ? (vec_t'(1) << ldNum) : '0;
    pendNext = ((pend & ~ackClr) | bus.strtDMAOp | bus.strtDMAOpInt) & ~bus.abortDMAOp;
    nextPtr  = W'((32'(ldNum) + 32'd1) % N);
  end

  // Request FSM, pointers and outstanding counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pend  <= '0;
      rrPtr <= '0;
      ldReq <= 1'b0;
      ldNum <= '0;
      cnt   <= '0;
`ifdef DMA_START_HI_PRIO_EN
      hiPtr   <= '0;
      grantHi <= 1'b0;
`endif
    end else begin
      pend <= pendNext;

      case (state)
        IDLE: begin
          if (winValid && (cnt < 4'(MAX_OUTSTANDING))) begin
            state <= REQ;
            ldReq <= 1'b1;
            ldNum <= winIdx;
`ifdef DMA_START_HI_PRIO_EN
            grantHi <= winHi;
`endif
          end
        end
        REQ: begin
          // Request is held (even across abort) until acknowledged
          if (bus.ldIntDscrptrAck) begin
            state <= IDLE;
            ldReq <= 1'b0;
`ifdef DMA_START_HI_PRIO_EN
            if (grantHi) hiPtr <= nextPtr;
            else         rrPtr <= nextPtr;
`else
            rrPtr <= nextPtr;
`endif
          end
        end
        default: begin
          state <= IDLE;
          ldReq <= 1'b0;
        end
      endcase

      // Simultaneous load and done cancel; done with nothing loaded is dropped
      if (doAck && !bus.dscrptrDone) begin
        cnt <= 4'(cnt + 4'd1);
      end else if (!doAck && bus.dscrptrDone && (cnt != 4'd0)) begin
        cnt <= 4'(cnt - 4'd1);
      end
    end
  end

  assign bus.ldDscrptr      = ldReq;
  assign bus.ldDscrptrNum   = ldNum;
  assign bus.pendStat       = pend;
  assign bus.outstandingCnt = cnt;

endmodule

// File: tb/tb_dma_start_sched.sv
// Directed self-checking bench for dma_start_sched (N=4, MAX_OUTSTANDING=2).
module tb_dma_start_sched;
  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  dma_start_sched_if #(.NUM_INT_BDS(N), .NUM_INT_BDS_WIDTH(W)) bus ();

  dma_start_sched #(
    .NUM_INT_BDS(N), .NUM_INT_BDS_WIDTH(W), .MAX_OUTSTANDING(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic ld, input logic [1:0] num,
                        input logic [3:0] pnd, input logic [3:0] cnt);
    chk({tag, ".ld"},   32'(bus.ldDscrptr),      32'(ld));
    chk({tag, ".num"},  32'(bus.ldDscrptrNum),   32'(num));
    chk({tag, ".pend"}, 32'(bus.pendStat),       32'(pnd));
    chk({tag, ".cnt"},  32'(bus.outstandingCnt), 32'(cnt));
  endtask

  initial begin
    logic [1:0] expOrder [4];
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.strtDMAOp       = '0;
    bus.strtDMAOpInt    = '0;
    bus.abortDMAOp      = '0;
    bus.ldIntDscrptrAck = 1'b0;
    bus.dscrptrDone     = 1'b0;
`ifdef DMA_START_HI_PRIO_EN
    bus.hiPrio = '0;
`endif
    tick();
    tick();
    chkOut("reset", 1'b0, 2'd0, 4'b0000, 4'd0);
    resetn = 1'b1;
    tick();

    // Start 1010: pending next cycle, request num=1 one cycle later
    bus.strtDMAOp = 4'b1010;
    tick();
    bus.strtDMAOp = '0;
    chkOut("lat_pend", 1'b0, 2'd0, 4'b1010, 4'd0);
    tick();
    chkOut("grant1", 1'b1, 2'd1, 4'b1010, 4'd0);
    bus.ldIntDscrptrAck = 1'b1;
    tick();
    bus.ldIntDscrptrAck = 1'b0;
    chkOut("ack1", 1'b0, 2'd1, 4'b1000, 4'd1);
    tick();
    chkOut("grant3", 1'b1, 2'd3, 4'b1000, 4'd1);
    bus.ldIntDscrptrAck = 1'b1;
    tick();
    bus.ldIntDscrptrAck = 1'b0;
    chkOut("ack3", 1'b0, 2'd3, 4'b0000, 4'd2);
    tick();
    tick();
    chk("no_req_after", 32'(bus.ldDscrptr), 32'd0);

    // Outstanding limit reached: pending 0001 must wait for done
    bus.strtDMAOp = 4'b0001;
    tick();
    bus.strtDMAOp = '0;
    tick();
    tick();
    chkOut("limit_hold", 1'b0, 2'd3, 4'b0001, 4'd2);
    bus.dscrptrDone = 1'b1;
    tick();
    bus.dscrptrDone = 1'b0;
    chkOut("done_dec", 1'b0, 2'd3, 4'b0001, 4'd1);
    tick();
    chkOut("grant0", 1'b1, 2'd0, 4'b0001, 4'd1);
    // Ack and done together leave the count unchanged
    bus.ldIntDscrptrAck = 1'b1;
    bus.dscrptrDone     = 1'b1;
    tick();
    bus.ldIntDscrptrAck = 1'b0;
    bus.dscrptrDone     = 1'b0;
    chkOut("ack_done", 1'b0, 2'd0, 4'b0000, 4'd1);
    bus.dscrptrDone = 1'b1;
    tick();
    chk("done_to0", 32'(bus.outstandingCnt), 32'd0);
    tick();
    bus.dscrptrDone = 1'b0;
    chk("done_at0", 32'(bus.outstandingCnt), 32'd0);

    // Pointer is 1: pending 1100 grants 2; abort of granted and of bit 3
    bus.strtDMAOp = 4'b1100;
    tick();
    bus.strtDMAOp = '0;
    tick();
    chkOut("grant2", 1'b1, 2'd2, 4'b1100, 4'd0);
    bus.abortDMAOp = 4'b1100;
    tick();
    bus.abortDMAOp = '0;
    chkOut("abort_hold", 1'b1, 2'd2, 4'b0000, 4'd0);
    tick();
    chkOut("abort_hold2", 1'b1, 2'd2, 4'b0000, 4'd0);
    bus.ldIntDscrptrAck = 1'b1;
    tick();
    bus.ldIntDscrptrAck = 1'b0;
    chkOut("ack2", 1'b0, 2'd2, 4'b0000, 4'd1);
    tick();
    tick();
    tick();
    chk("bit3_never", 32'(bus.ldDscrptr), 32'd0);
    // Ack in IDLE ignored
    bus.ldIntDscrptrAck = 1'b1;
    tick();
    bus.ldIntDscrptrAck = 1'b0;
    chk("idle_ack", 32'(bus.outstandingCnt), 32'd1);
    // Abort wins over simultaneous start
    bus.strtDMAOp  = 4'b0001;
    bus.abortDMAOp = 4'b0001;
    tick();
    bus.strtDMAOp  = '0;
    bus.abortDMAOp = '0;
    chk("abort_wins", 32'(bus.pendStat), 32'd0);

    // Pointer is 3: pending 0110 via chaining input grants 1 (wrap search)
    bus.strtDMAOpInt = 4'b0110;
    tick();
    bus.strtDMAOpInt = '0;
    tick();
    chkOut("wrap_grant", 1'b1, 2'd1, 4'b0110, 4'd1);
    // Reset mid-request clears outputs immediately
    resetn = 1'b0;
    #2;
    chkOut("async_rst", 1'b0, 2'd0, 4'b0000, 4'd0);
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
    chkOut("post_rst", 1'b0, 2'd0, 4'b0000, 4'd0);

    // All four pending from pointer 0: order 0,1,2,3
    expOrder[0] = 2'd0;
    expOrder[1] = 2'd1;
    expOrder[2] = 2'd2;
    expOrder[3] = 2'd3;
    bus.strtDMAOp = 4'b1111;
    tick();
    bus.strtDMAOp = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d.ld", k),  32'(bus.ldDscrptr),    32'd1);
      chk($sformatf("rr%0d.num", k), 32'(bus.ldDscrptrNum), 32'(expOrder[k]));
      bus.ldIntDscrptrAck = 1'b1;
      bus.dscrptrDone     = 1'b1;
      tick();
      bus.ldIntDscrptrAck = 1'b0;
      bus.dscrptrDone     = 1'b0;
      chk($sformatf("rr%0d.gap", k), 32'(bus.ldDscrptr), 32'd0);
      tick();
    end
    tick();
    chkOut("rr_end", 1'b0, 2'd3, 4'b0000, 4'd0);

`ifdef DMA_START_HI_PRIO_EN
    // High-priority descriptor 3 wins first, then normal round-robin 0,1,2
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    expOrder[0] = 2'd3;
    expOrder[1] = 2'd0;
    expOrder[2] = 2'd1;
    expOrder[3] = 2'd2;
    bus.hiPrio    = 4'b1000;
    bus.strtDMAOp = 4'b1111;
    tick();
    bus.strtDMAOp = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hp%0d.ld", k),  32'(bus.ldDscrptr),    32'd1);
      chk($sformatf("hp%0d.num", k), 32'(bus.ldDscrptrNum), 32'(expOrder[k]));
      bus.ldIntDscrptrAck = 1'b1;
      bus.dscrptrDone     = 1'b1;
      tick();
      bus.ldIntDscrptrAck = 1'b0;
      bus.dscrptrDone     = 1'b0;
      tick();
    end
    chk("hp_end", 32'(bus.pendStat), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
